// File: rtl/cpu_phase_pkg.sv
// Phase codes and FSM state type shared by the phase controller and the p1-p5 stage modules.
package cpu_phase_pkg;

  localparam logic [2:0] PH_IDLE   = 3'b000;
  localparam logic [2:0] PH_FETCH  = 3'b001;
  localparam logic [2:0] PH_DECODE = 3'b010;
  localparam logic [2:0] PH_EXEC   = 3'b011;
  localparam logic [2:0] PH_MEM    = 3'b100;
  localparam logic [2:0] PH_WB     = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P1,
    ST_P2,
    ST_P3,
    ST_P4,
    ST_P5,
    ST_HALT
  } phase_state_t;

  // HALT shares the idle code on the bus; stages tell them apart via 'halted'.
  function automatic logic [2:0] phase_code(input phase_state_t s);
    case (s)
      ST_P1:   return PH_FETCH;
      ST_P2:   return PH_DECODE;
      ST_P3:   return PH_EXEC;
      ST_P4:   return PH_MEM;
      ST_P5:   return PH_WB;
      default: return PH_IDLE;
    endcase
  endfunction

  function automatic logic is_active(input phase_state_t s);
    return (s == ST_P1) || (s == ST_P2) || (s == ST_P3) ||
           (s == ST_P4) || (s == ST_P5);
  endfunction

endpackage

// File: rtl/phase_controller.sv
// Five-phase sequencer for the non-pipelined CPU: start/stop, single-step,
// halt handling, per-phase stall hold and a retired-instruction counter.
module phase_controller
  import cpu_phase_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             step_mode,
  input  logic             stall,
  input  logic             halt_req,
  output logic [2:0]       state,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  phase_state_t fsm;
  phase_state_t next_fsm;
  logic         stop_pending;
  logic         retire;

  always_comb begin
    next_fsm = fsm;
    retire   = 1'b0;
    case (fsm)
      ST_IDLE: if (start) next_fsm = ST_P1;
      ST_P1:   if (!stall) next_fsm = ST_P2;
      ST_P2:   if (!stall) next_fsm = ST_P3;
      ST_P3:   if (!stall) next_fsm = ST_P4;
      ST_P4:   if (!stall) next_fsm = ST_P5;
      ST_P5: begin
        // A stop arriving in the completing cycle is taken at this same boundary.
        if (!stall) begin
          retire = 1'b1;
          if (halt_req)
            next_fsm = ST_HALT;
          else if (stop_pending || stop || step_mode)
            next_fsm = ST_IDLE;
          else
            next_fsm = ST_P1;
        end
      end
      ST_HALT: next_fsm = ST_HALT;
      default: next_fsm = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm          <= ST_IDLE;
      state        <= PH_IDLE;
      running      <= 1'b0;
      halted       <= 1'b0;
      instr_count  <= '0;
      stop_pending <= 1'b0;
    end else begin
      fsm     <= next_fsm;
      state   <= phase_code(next_fsm);
      running <= is_active(next_fsm);
      halted  <= (next_fsm == ST_HALT);
      if (retire)
        instr_count <= instr_count + CNT_W'(1);
      if (next_fsm == ST_IDLE || next_fsm == ST_HALT)
        stop_pending <= 1'b0;
      else if (stop && is_active(fsm))
        stop_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_phase_controller.sv
// Table-driven scoreboard bench for phase_controller (16-bit and 4-bit counter instances).
module tb_phase_controller;
  import cpu_phase_pkg::*;

  typedef struct {
    logic        rst;
    logic        st;
    logic        sp;
    logic        sm;
    logic        sl;
    logic        hr;
    logic [2:0]  e_state;
    logic        e_run;
    logic        e_halt;
    logic [15:0] e_cnt;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        step_mode = 1'b0;
  logic        stall = 1'b0;
  logic        halt_req = 1'b0;
  logic [2:0]  state16, state4;
  logic        running16, running4, halted16, halted4;
  logic [15:0] count16;
  logic [3:0]  count4;

  int   tests_run = 0;
  int   tests_failed = 0;
  vec_t vectors[$];
  vec_t exp_q[$];

  always #5 clock = ~clock;

  phase_controller #(.CNT_W(16)) u_dut16 (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .step_mode(step_mode), .stall(stall), .halt_req(halt_req),
    .state(state16), .running(running16), .halted(halted16),
    .instr_count(count16)
  );

  phase_controller #(.CNT_W(4)) u_dut4 (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .step_mode(step_mode), .stall(stall), .halt_req(halt_req),
    .state(state4), .running(running4), .halted(halted4),
    .instr_count(count4)
  );

  function automatic void add(input logic rst, input logic st, input logic sp,
                              input logic sm, input logic sl, input logic hr,
                              input logic [2:0] es, input logic eh, input int ec);
    vec_t v;
    v.rst = rst; v.st = st; v.sp = sp; v.sm = sm; v.sl = sl; v.hr = hr;
    v.e_state = es;
    v.e_run   = (es != PH_IDLE);
    v.e_halt  = eh;
    v.e_cnt   = ec[15:0];
    vectors.push_back(v);
  endfunction

  task automatic cmp(input string name, input int idx, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL vec %0d %s: got %0d, expected %0d", idx, name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset     = v.rst;
    start     = v.st;
    stop      = v.sp;
    step_mode = v.sm;
    stall     = v.sl;
    halt_req  = v.hr;
    exp_q.push_back(v);
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    if (exp_q.size() == 0) begin
      cmp("scoreboard_empty", idx, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    cmp("state",       idx, int'(state16),   int'(e.e_state));
    cmp("running",     idx, int'(running16), int'(e.e_run));
    cmp("halted",      idx, int'(halted16),  int'(e.e_halt));
    cmp("count16",     idx, int'(count16),   int'(e.e_cnt));
    cmp("state_w4",    idx, int'(state4),    int'(e.e_state));
    cmp("count4",      idx, int'(count4),    int'(e.e_cnt[3:0]));
    cmp("run_halt_ex", idx, int'(running4 & halted4), 0);
  endtask

  initial begin
    int c;
    int cycles;

    // Reset; stop/stall in IDLE are ignored; start pulse then free run.
    add(1,0,0,0,0,0, 0,0,0);
    add(0,0,0,0,0,0, 0,0,0);
    add(0,0,1,0,1,0, 0,0,0);
    add(0,1,0,0,0,0, 1,0,0);
    add(0,0,0,0,0,0, 2,0,0);
    add(0,0,0,0,0,0, 3,0,0);
    add(0,0,0,0,0,0, 4,0,0);
    add(0,0,0,0,0,0, 5,0,0);
    add(0,0,0,0,0,0, 1,0,1);
    add(0,0,0,0,0,0, 2,0,1);
    add(0,1,0,0,0,1, 3,0,1);
    add(0,0,0,0,0,0, 4,0,1);
    add(0,0,0,0,0,0, 5,0,1);
    add(0,0,0,0,0,0, 1,0,2);
    add(0,0,0,0,0,0, 2,0,2);
    add(0,0,0,0,0,0, 3,0,2);
    // Stall three cycles in P4, then a stalled P5 with halt_req must not decide.
    add(0,0,0,0,0,0, 4,0,2);
    add(0,0,0,0,1,0, 4,0,2);
    add(0,0,0,0,1,0, 4,0,2);
    add(0,0,0,0,1,0, 4,0,2);
    add(0,0,0,0,0,0, 5,0,2);
    add(0,0,0,0,1,1, 5,0,2);
    add(0,0,0,0,0,0, 1,0,3);
    // Single-step mode: bursts separated by IDLE.
    add(0,0,0,1,0,0, 2,0,3);
    add(0,0,0,1,0,0, 3,0,3);
    add(0,0,0,1,0,0, 4,0,3);
    add(0,0,0,1,0,0, 5,0,3);
    add(0,0,0,1,0,0, 0,0,4);
    add(0,0,0,1,1,0, 0,0,4);
    add(0,1,0,1,0,0, 1,0,4);
    add(0,1,0,1,0,0, 2,0,4);
    add(0,0,0,1,0,0, 3,0,4);
    add(0,0,0,1,0,0, 4,0,4);
    add(0,0,0,1,0,0, 5,0,4);
    add(0,0,0,1,0,0, 0,0,5);
    add(0,0,0,1,0,0, 0,0,5);
    add(0,1,0,1,0,0, 1,0,5);
    add(0,0,0,1,0,0, 2,0,5);
    add(0,0,0,1,0,0, 3,0,5);
    add(0,0,0,1,0,0, 4,0,5);
    add(0,0,0,1,0,0, 5,0,5);
    add(0,0,0,1,0,0, 0,0,6);
    // Stop pulse in P2 finishes the instruction then idles.
    add(0,1,0,0,0,0, 1,0,6);
    add(0,0,0,0,0,0, 2,0,6);
    add(0,0,1,0,0,0, 3,0,6);
    add(0,0,0,0,0,0, 4,0,6);
    add(0,0,0,0,0,0, 5,0,6);
    add(0,0,0,0,0,0, 0,0,7);
    add(0,0,1,0,0,0, 0,0,7);
    add(0,1,0,0,0,0, 1,0,7);
    add(0,0,0,0,0,0, 2,0,7);
    add(0,0,0,0,0,0, 3,0,7);
    add(0,0,0,0,0,0, 4,0,7);
    add(0,0,0,0,0,0, 5,0,7);
    add(0,0,0,0,0,0, 1,0,8);
    add(0,0,0,0,0,0, 2,0,8);
    add(0,0,0,0,0,0, 3,0,8);
    add(0,0,0,0,0,0, 4,0,8);
    add(0,0,0,0,0,0, 5,0,8);
    add(0,0,1,0,0,0, 0,0,9);
    // halt_req outside P5 ignored; halt wins over stop/step; HALT is sticky.
    add(0,1,0,0,0,0, 1,0,9);
    add(0,0,0,0,0,0, 2,0,9);
    add(0,0,0,0,0,1, 3,0,9);
    add(0,0,0,0,0,1, 4,0,9);
    add(0,0,0,0,0,0, 5,0,9);
    add(0,0,1,1,0,1, 0,1,10);
    add(0,1,0,0,0,0, 0,1,10);
    add(0,1,1,0,1,0, 0,1,10);
    add(1,1,0,0,0,0, 0,0,0);
    // Sixteen instructions: the 4-bit counter wraps to 0.
    add(0,1,0,0,0,0, 1,0,0);
    for (int i = 0; i < 16; i++) begin
      add(0,0,0,0,0,0, 2,0,i);
      add(0,0,0,0,0,0, 3,0,i);
      add(0,0,0,0,0,0, 4,0,i);
      add(0,0,0,0,0,0, 5,0,i);
      add(0,0,0,0,0,0, 1,0,i+1);
    end
    add(0,0,0,0,0,0, 2,0,16);
    add(0,0,0,0,0,0, 3,0,16);
    add(1,1,0,0,0,0, 0,0,0);
    add(0,1,0,0,0,0, 1,0,0);

    c = 0;
    foreach (vectors[i]) begin
      applyStimulus(vectors[i]);
      @(posedge clock);
      #1;
      checkOutput(c);
      c++;
    end

    // Hand sequence: from P1, an unstalled run reaches P5 after exactly four edges.
    start = 1'b0;
    cycles = 0;
    while (state16 != PH_WB && cycles < 20) begin
      @(posedge clock);
      #1;
      cycles++;
    end
    cmp("p1_to_p5_cycles", c, cycles, 4);
    @(posedge clock);
    #1;
    cmp("wrap_after_wb", c + 1, int'(count4), 1);
    cmp("back_to_back",  c + 1, int'(state16), int'(PH_FETCH));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
